// File: rtl/seq_mult.sv
// Multi-cycle shift-add multiplier with per-operation signed/unsigned mode.
// Operands are latched as magnitudes; the sign is applied on completion.
module seq_mult #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcd_q, mcd_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // -2^(W-1) negates to itself, which reads correctly as unsigned 2^(W-1)
  assign a_neg = is_signed & multiplier[WIDTH-1];
  assign b_neg = is_signed & multiplicand[WIDTH-1];
  assign mag_a = a_neg ? (~multiplier + WIDTH'(1))
                       : multiplier;
  assign mag_b = b_neg ? (~multiplicand + WIDTH'(1))
                       : multiplicand;

  // Low half of acc holds the shifting multiplier
  assign addend = acc_q[0] ? mcd_q : '0;
  assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + {1'b0, addend};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          mcd_d   = mag_b;
          neg_d   = a_neg ^ b_neg;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = S_DONE;
          prod_d  = neg_q ? (~acc_q + (2*WIDTH)'(1))
                          : acc_q;
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcd_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule
